// File: rtl/bht_update_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bht_update_queue (with bht_update_queue_pkg)                     |
// | Brief   : Collects resolved branch outcomes from two commit-side resolve   |
// |           ports and sends them to the BHT in program order, one per cycle. |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

package bht_update_queue_pkg;
  // Virtual address width of a branch PC.
  parameter int VLEN = 64;

  // Update handed to the branch history table.
  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;
endpackage

module bht_update_queue
  import bht_update_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic [1:0]                 resolve_valid_i,
  input  logic [1:0][VLEN-1:0]       resolve_pc_i,
  input  logic [1:0]                 resolve_taken_i,
  output logic                       ready_o,
  output bht_update_t                bht_update_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic                       overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  // Registered queue state
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            overflow;

  // Entry storage; contents are only meaningful between head and tail
  logic [VLEN-1:0] pc_mem    [DEPTH];
  logic            taken_mem [DEPTH];

  // Per-cycle control
  logic            pop;
  logic            elig0;
  logic            elig1;
  logic [CW-1:0]   free_slots;
  logic            accept0;
  logic            accept1;
  logic            dropped;
  logic [PW-1:0]   wr_addr1;

  // Pop/push decisions: the BHT never back-pressures, so a non-empty queue
  // always pops unless flushing; the same-cycle pop frees one slot for pushes.
  always_comb begin
    pop        = (count != '0) && !flush_i;
    elig0      = resolve_valid_i[0] && !debug_mode_i && !flush_i;
    elig1      = resolve_valid_i[1] && !debug_mode_i && !flush_i;
    free_slots = DEPTH_C - count + CW'(pop);
    // Port 0 is older, so it claims the first free slot; port 1 is dropped first.
    accept0    = elig0 && (free_slots != '0);
    accept1    = elig1 && (elig0 ? (free_slots >= TWO_C) : (free_slots != '0));
    dropped    = (elig0 && !accept0) || (elig1 && !accept1);
    // Port 1 lands right after port 0 when both are accepted, else at tail.
    wr_addr1   = tail + PW'(accept0);
  end

  // Pointer, count and overflow registers; reset beats flush beats push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      head     <= head + PW'(pop);
      tail     <= tail + PW'(accept0) + PW'(accept1);
      count    <= count + CW'(accept0) + CW'(accept1) - CW'(pop);
      overflow <= dropped;
    end
  end

  // Entry storage writes; no reset needed since count gates every read.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (accept0) begin
        pc_mem[tail]    <= resolve_pc_i[0];
        taken_mem[tail] <= resolve_taken_i[0];
      end
      if (accept1) begin
        pc_mem[wr_addr1]    <= resolve_pc_i[1];
        taken_mem[wr_addr1] <= resolve_taken_i[1];
      end
    end
  end

  // Outputs come from registered state only; pc/taken are zeroed when empty.
  always_comb begin
    bht_update_o       = '0;
    bht_update_o.valid = (count != '0);
    if (count != '0) begin
      bht_update_o.pc    = pc_mem[head];
      bht_update_o.taken = taken_mem[head];
    end
    occupancy_o = count;
    overflow_o  = overflow;
    ready_o     = (DEPTH_C - count) >= TWO_C;
  end

endmodule
`default_nettype wire

// File: tb/tb_bht_update_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bht_update_queue                                              |
// | Brief   : Randomised self-checking bench with a queue-based reference      |
// |           model and a few hand-computed directed expectations.             |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_bht_update_queue;
  import bht_update_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 flush_i = 1'b0;
  logic                 debug_mode_i = 1'b0;
  logic [1:0]           resolve_valid_i = '0;
  logic [1:0][VLEN-1:0] resolve_pc_i = '0;
  logic [1:0]           resolve_taken_i = '0;
  logic                 ready_o;
  bht_update_t          bht_update_o;
  logic [CW-1:0]        occupancy_o;
  logic                 overflow_o;

  bht_update_queue #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .debug_mode_i    (debug_mode_i),
    .resolve_valid_i (resolve_valid_i),
    .resolve_pc_i    (resolve_pc_i),
    .resolve_taken_i (resolve_taken_i),
    .ready_o         (ready_o),
    .bht_update_o    (bht_update_o),
    .occupancy_o     (occupancy_o),
    .overflow_o      (overflow_o)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of {pc, taken} entries plus an overflow flag.
  logic [VLEN:0] model_q [$];
  logic          model_ovf = 1'b0;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [VLEN:0] act, input logic [VLEN:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    bit drop;
    int free_slots;
    if (rst_i || flush_i) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      drop = 1'b0;
      free_slots = DEPTH - model_q.size();
      if (model_q.size() != 0) begin
        void'(model_q.pop_front());
        free_slots++;
      end
      for (int k = 0; k < 2; k++) begin
        if (resolve_valid_i[k] && !debug_mode_i) begin
          if (free_slots > 0) begin
            model_q.push_back({resolve_pc_i[k], resolve_taken_i[k]});
            free_slots--;
          end else begin
            drop = 1'b1;
          end
        end
      end
      model_ovf = drop;
    end
  endtask

  // Compare every DUT output with the model.
  task automatic compare_all();
    logic [VLEN:0] head_e;
    head_e = (model_q.size() != 0) ? model_q[0] : '0;
    chk("valid",     {{VLEN{1'b0}}, bht_update_o.valid}, {{VLEN{1'b0}}, model_q.size() != 0});
    chk("pc",        {1'b0, bht_update_o.pc},            {1'b0, head_e[VLEN:1]});
    chk("taken",     {{VLEN{1'b0}}, bht_update_o.taken}, {{VLEN{1'b0}}, head_e[0]});
    chk("occupancy", (VLEN+1)'(occupancy_o),             (VLEN+1)'(model_q.size()));
    chk("ready",     {{VLEN{1'b0}}, ready_o},            {{VLEN{1'b0}}, (DEPTH - model_q.size()) >= 2});
    chk("overflow",  {{VLEN{1'b0}}, overflow_o},         {{VLEN{1'b0}}, model_ovf});
  endtask

  // One clock: inputs are already applied, update model at the edge, sample 1ns later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [1:0] v, input logic [VLEN-1:0] pc0, input logic [VLEN-1:0] pc1,
                       input logic [1:0] tk);
    resolve_valid_i = v;
    resolve_pc_i[0] = pc0;
    resolve_pc_i[1] = pc1;
    resolve_taken_i = tk;
  endtask

  task automatic idle();
    drive(2'b00, '0, '0, 2'b00);
  endtask

  initial begin
    // Reset
    rst_i = 1'b1;
    idle();
    step();
    step();
    chk("lit_reset_ready", {{VLEN{1'b0}}, ready_o}, 1);
    chk("lit_reset_occ", (VLEN+1)'(occupancy_o), 0);
    rst_i = 1'b0;

    // Single resolve on port 0
    drive(2'b01, 64'h8000_0010, '0, 2'b01);
    step();
    chk("lit_single_pc", {1'b0, bht_update_o.pc}, {1'b0, 64'h8000_0010});
    chk("lit_single_valid", {{VLEN{1'b0}}, bht_update_o.valid}, 1);
    idle();
    step();
    chk("lit_single_gone", {{VLEN{1'b0}}, bht_update_o.valid}, 0);

    // Ordering: A,B then C,D -> A,B,C,D out; occupancy 2,3,2,1,0
    drive(2'b11, 64'hA, 64'hB, 2'b01);
    step();
    chk("lit_ord_a", {1'b0, bht_update_o.pc}, {1'b0, 64'hA});
    chk("lit_ord_occ1", (VLEN+1)'(occupancy_o), 2);
    drive(2'b11, 64'hC, 64'hD, 2'b10);
    step();
    chk("lit_ord_b", {1'b0, bht_update_o.pc}, {1'b0, 64'hB});
    chk("lit_ord_occ2", (VLEN+1)'(occupancy_o), 3);
    chk("lit_ord_ready_lo", {{VLEN{1'b0}}, ready_o}, 0);
    idle();
    step();
    chk("lit_ord_c", {1'b0, bht_update_o.pc}, {1'b0, 64'hC});
    step();
    chk("lit_ord_d", {1'b0, bht_update_o.pc}, {1'b0, 64'hD});
    step();
    chk("lit_ord_empty", (VLEN+1)'(occupancy_o), 0);

    // Overflow: fill to 4 (2, 3, 4), then E,F with count 4 -> E kept, F dropped
    drive(2'b11, 64'h11, 64'h12, 2'b00); step();
    drive(2'b11, 64'h13, 64'h14, 2'b00); step();
    drive(2'b11, 64'h15, 64'h16, 2'b00); step();
    chk("lit_full_occ", (VLEN+1)'(occupancy_o), 4);
    drive(2'b11, 64'hE, 64'hF, 2'b11); step();
    chk("lit_ovf_pulse", {{VLEN{1'b0}}, overflow_o}, 1);
    chk("lit_ovf_occ", (VLEN+1)'(occupancy_o), 4);
    idle(); step();
    chk("lit_ovf_clear", {{VLEN{1'b0}}, overflow_o}, 0);
    step(); step();
    chk("lit_ovf_e", {1'b0, bht_update_o.pc}, {1'b0, 64'hE});

    // Flush mid-drain with port 0 valid
    drive(2'b11, 64'h21, 64'h22, 2'b00); step();
    drive(2'b01, 64'h23, 64'h0, 2'b00); flush_i = 1'b1; step();
    flush_i = 1'b0;
    chk("lit_flush_occ", (VLEN+1)'(occupancy_o), 0);
    idle(); step();

    // Debug mode: queued entries drain, nothing new, no overflow
    drive(2'b11, 64'h31, 64'h32, 2'b00); step();
    debug_mode_i = 1'b1;
    drive(2'b11, 64'h33, 64'h34, 2'b11); step();
    drive(2'b11, 64'h35, 64'h36, 2'b11); step();
    chk("lit_dbg_occ", (VLEN+1)'(occupancy_o), 0);
    chk("lit_dbg_ovf", {{VLEN{1'b0}}, overflow_o}, 0);
    debug_mode_i = 1'b0;
    idle(); step();

    // Randomised traffic, mostly honouring ready_o but sometimes violating it
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(0, 3));
      if (!ready_o && ($urandom_range(0, 3) != 0)) v = 2'b00;
      drive(v, {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
            2'($urandom_range(0, 3)));
      flush_i      = ($urandom_range(0, 29) == 0);
      debug_mode_i = ($urandom_range(0, 9) == 0);
      rst_i        = ($urandom_range(0, 59) == 0);
      step();
    end
    rst_i = 1'b0; flush_i = 1'b0; debug_mode_i = 1'b0; idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
